// File: rtl/kernel_launch_ctrl.sv
// Kernel launch front end: host register file, launch FSM, shadowed kernel
// configuration for the block dispatcher, cycle counter and completion irq.
//
// Handshake note: the host port is strobe based. host_wr_en writes in the
// cycle it is high. host_rd_en is answered by host_rd_valid exactly one cycle
// later, with the value the register held before any same-cycle write.
// Dispatcher control follows a plain level protocol: disp_start stays high
// for the whole RUN phase and drops when the controller sees disp_done.
module kernel_launch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int BLOCK_W  = 8,
  parameter int THREAD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_wr_en,
  input  logic                host_rd_en,
  input  logic [2:0]          host_addr,
  input  logic [31:0]         host_wdata,
  output logic [31:0]         host_rdata,
  output logic                host_rd_valid,
  output logic                disp_start,
  output logic                disp_reset,
  input  logic                disp_done,
  output logic [BLOCK_W-1:0]  cfg_num_blocks,
  output logic [THREAD_W-1:0] cfg_threads_per_block,
  output logic [ADDR_W-1:0]   cfg_base_pc,
  output logic                irq,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [BLOCK_W-1:0]  num_blocks;
    logic [THREAD_W-1:0] threads;
    logic [ADDR_W-1:0]   base_pc;
  } kernel_config_t;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_NBLK    = 3'd1;
  localparam logic [2:0] A_THREADS = 3'd2;
  localparam logic [2:0] A_PC      = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;
  localparam logic [2:0] A_CYCLES  = 3'd5;

  state_e              state_q, state_d;
  kernel_config_t      shadow_q, shadow_d;
  logic [BLOCK_W-1:0]  num_blocks_q, num_blocks_d;
  logic [THREAD_W-1:0] threads_q, threads_d;
  logic [ADDR_W-1:0]   base_pc_q, base_pc_d;
  logic [31:0]         cycles_q, cycles_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                cfg_err_q, cfg_err_d;
  logic                disp_start_q, disp_start_d;
  logic                disp_reset_q, disp_reset_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rd_valid_q, rd_valid_d;

  logic wr_ctrl, launch, clear, abort, busy, wr_cfg;
  logic unused_wdata;

  assign unused_wdata = ^host_wdata;

  // Decode the host strobe into control commands.
  always_comb begin
    wr_ctrl = host_wr_en && (host_addr == A_CTRL);
    launch  = wr_ctrl && host_wdata[0];
    clear   = wr_ctrl && host_wdata[1];
    abort   = wr_ctrl && host_wdata[2];
    wr_cfg  = host_wr_en && (host_addr inside {A_NBLK, A_THREADS, A_PC});
    busy    = (state_q inside {S_PREP, S_RUN, S_DRAIN});
  end

  // Next-state logic: FSM, register file, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    num_blocks_d = num_blocks_q;
    threads_d    = threads_q;
    base_pc_d    = base_pc_q;
    cycles_d     = cycles_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    cfg_err_d    = cfg_err_q;
    rdata_d      = rdata_q;
    rd_valid_d   = host_rd_en;

    if (wr_ctrl) irq_en_d = host_wdata[3];
    if (clear)   cfg_err_d = 1'b0;

    // Config writes during a launch would tear the kernel setup; drop them.
    if (wr_cfg) begin
      if (busy) begin
        cfg_err_d = 1'b1;
      end else begin
        case (host_addr)
          A_NBLK:    num_blocks_d = host_wdata[BLOCK_W-1:0];
          A_THREADS: threads_d    = host_wdata[THREAD_W-1:0];
          default:   base_pc_d    = host_wdata[ADDR_W-1:0];
        endcase
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // CLEAR is applied before LAUNCH when both arrive together.
        if (state_q == S_DONE && clear) begin
          state_d   = S_IDLE;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end
        if (launch) begin
          shadow_d  = '{num_blocks: num_blocks_q, threads: threads_q,
                        base_pc: base_pc_q};
          cycles_d  = '0;
          aborted_d = 1'b0;
          if (num_blocks_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PREP;
            done_d  = 1'b0;
          end
        end
      end
      S_PREP: state_d = S_RUN;
      S_RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
        end else if (disp_done) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    disp_start_d = (state_d == S_RUN);
    disp_reset_d = (state_d == S_PREP) || (state_d == S_DRAIN);
    irq_d        = done_d && irq_en_d;

    if (host_rd_en) begin
      case (host_addr)
        A_CTRL:    rdata_d = {28'd0, irq_en_q, 3'd0};
        A_NBLK:    rdata_d = 32'(num_blocks_q);
        A_THREADS: rdata_d = 32'(threads_q);
        A_PC:      rdata_d = 32'(base_pc_q);
        A_STATUS:  rdata_d = {28'd0, cfg_err_q, aborted_q, done_q, busy};
        A_CYCLES:  rdata_d = cycles_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  // State and register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      num_blocks_q <= '0;
      threads_q    <= '0;
      base_pc_q    <= '0;
      cycles_q     <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      disp_start_q <= 1'b0;
      disp_reset_q <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      num_blocks_q <= num_blocks_d;
      threads_q    <= threads_d;
      base_pc_q    <= base_pc_d;
      cycles_q     <= cycles_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cfg_err_q    <= cfg_err_d;
      disp_start_q <= disp_start_d;
      disp_reset_q <= disp_reset_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign host_rdata            = rdata_q;
  assign host_rd_valid         = rd_valid_q;
  assign disp_start            = disp_start_q;
  assign disp_reset            = disp_reset_q;
  assign irq                   = irq_q;
  assign cfg_num_blocks        = shadow_q.num_blocks;
  assign cfg_threads_per_block = shadow_q.threads;
  assign cfg_base_pc           = shadow_q.base_pc;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Bench for kernel_launch_ctrl: directed scenario tasks plus a read scoreboard
// that pairs each expected read value with the next host_rd_valid response.
module tb_kernel_launch_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PREP  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr_en, host_rd_en;
  logic [2:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rd_valid;
  logic        disp_start, disp_reset, disp_done, irq;
  logic [7:0]  cfg_num_blocks, cfg_threads_per_block, cfg_base_pc;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  kernel_launch_ctrl #(.ADDR_W(8), .BLOCK_W(8), .THREAD_W(8)) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rd_valid(host_rd_valid),
    .disp_start(disp_start), .disp_reset(disp_reset), .disp_done(disp_done),
    .cfg_num_blocks(cfg_num_blocks),
    .cfg_threads_per_block(cfg_threads_per_block),
    .cfg_base_pc(cfg_base_pc), .irq(irq), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Read scoreboard: every read response consumes one expected value.
  always @(negedge clk) begin
    if (host_rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h, no read outstanding", host_rdata);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (host_rdata !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, host_rdata, e);
        end
      end
    end
  end

  // Driver tasks; each returns 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    host_wr_en = 1'b1;
    host_addr  = a;
    host_wdata = d;
    step();
    host_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    host_rd_en = 1'b1;
    host_addr  = a;
    step();
    host_rd_en = 1'b0;
    checks++;
    if (host_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_valid_latency(%s): got %b expected 1", n, host_rd_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; host_wr_en = 1'b0; host_rd_en = 1'b0;
    host_addr = '0; host_wdata = '0; disp_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if ({disp_start, disp_reset, irq, host_rd_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {disp_start, disp_reset, irq, host_rd_valid});
    end
    checks++;
    if ({cfg_num_blocks, cfg_threads_per_block, cfg_base_pc, dbg_state} !== {24'd0, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_cfg: got %h/%h/%h st %0d expected zeros",
               cfg_num_blocks, cfg_threads_per_block, cfg_base_pc, dbg_state);
    end
    for (int a = 0; a < 8; a++) host_read(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
  endtask

  task automatic test_launch_run();
    host_write(3'd1, 32'd4);
    host_write(3'd2, 32'd8);
    host_write(3'd3, 32'h10);
    host_write(3'd0, 32'h9);          // IRQ_EN | LAUNCH
    checks++;
    if ({disp_reset, disp_start, dbg_state} !== {2'b10, ST_PREP}) begin
      errors++;
      $display("FAIL prep_cycle: got rst=%b start=%b st=%0d expected 1 0 %0d",
               disp_reset, disp_start, dbg_state, ST_PREP);
    end
    step();                           // first RUN cycle
    checks++;
    if ({disp_reset, disp_start} !== 2'b01) begin
      errors++;
      $display("FAIL run_start: got rst=%b start=%b expected 0 1", disp_reset, disp_start);
    end
    checks++;
    if ({cfg_num_blocks, cfg_threads_per_block, cfg_base_pc} !== {8'd4, 8'd8, 8'h10}) begin
      errors++;
      $display("FAIL shadow_cfg: got %h/%h/%h expected 04/08/10",
               cfg_num_blocks, cfg_threads_per_block, cfg_base_pc);
    end
    for (int i = 2; i <= 20; i++) begin
      step();
      checks++;
      if (disp_start !== 1'b1 || irq !== 1'b0) begin
        errors++;
        $display("FAIL run_hold cycle %0d: got start=%b irq=%b expected 1 0", i, disp_start, irq);
      end
    end
    disp_done = 1'b1;                 // seen in RUN cycle 20
    step();
    disp_done = 1'b0;
    checks++;
    if ({disp_start, disp_reset, dbg_state} !== {2'b01, ST_DRAIN}) begin
      errors++;
      $display("FAIL drain_cycle: got start=%b rst=%b st=%0d expected 0 1 %0d",
               disp_start, disp_reset, dbg_state, ST_DRAIN);
    end
    step();
    checks++;
    if ({disp_reset, irq, dbg_state} !== {2'b01, ST_DONE}) begin
      errors++;
      $display("FAIL done_irq: got rst=%b irq=%b st=%0d expected 0 1 %0d",
               disp_reset, irq, dbg_state, ST_DONE);
    end
    host_read(3'd4, 32'b0010, "status_done");
    host_read(3'd5, 32'd20, "cycles_20");
    host_read(3'd0, 32'h8, "ctrl_irq_en");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_level: got %b expected 1", irq);
    end
    host_write(3'd0, 32'hA);          // IRQ_EN | CLEAR
    checks++;
    if ({irq, dbg_state} !== {1'b0, ST_IDLE}) begin
      errors++;
      $display("FAIL clear_irq: got irq=%b st=%0d expected 0 %0d", irq, dbg_state, ST_IDLE);
    end
    host_read(3'd4, 32'd0, "status_cleared");
  endtask

  task automatic test_busy_write();
    host_write(3'd0, 32'h9);          // relaunch, NUM_BLOCKS still 4
    step();                           // RUN
    host_write(3'd1, 32'd7);          // dropped
    checks++;
    if (cfg_num_blocks !== 8'd4) begin
      errors++;
      $display("FAIL busy_write_shadow: got %0d expected 4", cfg_num_blocks);
    end
    host_read(3'd4, 32'b1001, "status_cfg_err");
    host_read(3'd1, 32'd4, "nblk_unchanged");
    host_write(3'd0, 32'h9);          // LAUNCH while busy: ignored
    checks++;
    if (dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL launch_busy: got st=%0d expected %0d", dbg_state, ST_RUN);
    end
    host_read(3'd4, 32'b1001, "status_launch_busy");
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    step();                           // DONE
    host_write(3'd0, 32'h2);          // CLEAR, IRQ_EN off
    host_read(3'd4, 32'd0, "status_err_cleared");
  endtask

  task automatic test_zero_blocks();
    logic seen;
    host_write(3'd1, 32'd0);
    host_write(3'd0, 32'h1);
    seen = disp_start | disp_reset;
    checks++;
    if (dbg_state !== ST_DONE) begin
      errors++;
      $display("FAIL zero_blk_state: got %0d expected %0d", dbg_state, ST_DONE);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | disp_start | disp_reset;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL zero_blk_disp: got activity=%b expected 0", seen);
    end
    host_read(3'd4, 32'b0010, "status_zero_blk");
    host_write(3'd1, 32'd3);
    host_write(3'd0, 32'h3);          // CLEAR then LAUNCH from DONE
    checks++;
    if ({dbg_state, disp_reset} !== {ST_PREP, 1'b1}) begin
      errors++;
      $display("FAIL clear_launch: got st=%0d rst=%b expected %0d 1", dbg_state, disp_reset, ST_PREP);
    end
  endtask

  task automatic test_abort_done();
    step();                           // RUN
    repeat ($urandom_range(1, 4)) step();
    disp_done = 1'b1;
    host_write(3'd0, 32'hC);          // IRQ_EN | ABORT with disp_done
    disp_done = 1'b0;
    checks++;
    if (dbg_state !== ST_DRAIN) begin
      errors++;
      $display("FAIL abort_drain: got %0d expected %0d", dbg_state, ST_DRAIN);
    end
    step();
    host_read(3'd4, 32'b0110, "status_aborted");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL abort_irq: got %b expected 1", irq);
    end
    host_write(3'd0, 32'hA);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear_irq: got %b expected 0", irq);
    end
    host_read(3'd4, 32'd0, "status_abort_cleared");
  endtask

  task automatic test_regs();
    logic [31:0] v;
    v = 32'($urandom_range(0, 255));
    host_write(3'd2, v);
    host_wr_en = 1'b1; host_rd_en = 1'b1;
    host_addr = 3'd1; host_wdata = 32'h1FF;
    exp_q.push_back(32'd3); name_q.push_back("rd_before_wr");
    step();
    host_wr_en = 1'b0; host_rd_en = 1'b0;
    host_read(3'd1, 32'hFF, "truncate_nblk");
    host_read(3'd2, v, "threads_rand");
    host_write(3'd6, 32'hFFFF_FFFF);
    host_read(3'd6, 32'd0, "addr6_zero");
    host_read(3'd7, 32'd0, "addr7_zero");
  endtask

  task automatic test_reset_mid_run();
    host_write(3'd1, 32'd5);
    host_write(3'd0, 32'h9);
    repeat (4) step();
    reset = 1'b1;
    step();
    checks++;
    if ({disp_start, disp_reset, irq, host_rd_valid, dbg_state} !== {4'b0000, ST_IDLE}) begin
      errors++;
      $display("FAIL mid_reset: got start=%b rst=%b irq=%b rv=%b st=%0d expected zeros",
               disp_start, disp_reset, irq, host_rd_valid, dbg_state);
    end
    checks++;
    if ({cfg_num_blocks, cfg_threads_per_block, cfg_base_pc} !== 24'd0) begin
      errors++;
      $display("FAIL mid_reset_cfg: got %h/%h/%h expected 0",
               cfg_num_blocks, cfg_threads_per_block, cfg_base_pc);
    end
    reset = 1'b0;
    for (int a = 0; a < 6; a++) host_read(3'(a), 32'd0, $sformatf("post_reset_reg%0d", a));
  endtask

  initial begin
    test_reset();
    test_launch_run();
    test_busy_write();
    test_zero_blocks();
    test_abort_done();
    test_regs();
    test_reset_mid_run();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_outstanding: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
